// File: rtl/blink_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package blink_pkg;

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT} mode_t;
  typedef enum logic [1:0] {OS_IDLE, OS_HIGH, OS_DONE} os_t;

  localparam logic [1:0] SEL_MODE = 2'd0;
  localparam logic [1:0] SEL_HP   = 2'd1;
  localparam logic [1:0] SEL_DUTY = 2'd2;

  // Index width that never collapses to zero bits.
  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_multi_if.sv
// Config bus and pattern outputs of blink_multi.
interface blink_multi_if #(
  parameter int NCH   = 8,
  parameter int CNT_W = 16
);
  localparam int CH_W = blink_pkg::ch_w(NCH);

  logic             ena;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic [NCH-1:0]   out;
  logic [NCH-1:0]   busy;

  modport master (output ena, cfg_we, cfg_ch, cfg_sel, cfg_data, input out, busy);
  modport slave  (input ena, cfg_we, cfg_ch, cfg_sel, cfg_data, output out, busy);
endinterface

// File: rtl/blink_channel.sv
// One LED channel: mode/half-period registers, tick counter, blink phase, ONESHOT FSM.
// BLINK_PWM_EN adds an 8-bit duty register gating the pattern against the shared pwm count.
module blink_channel import blink_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             tick_i,
  input  logic             we_mode_i,
  input  logic             we_hp_i,
`ifdef BLINK_PWM_EN
  input  logic             we_duty_i,
  input  logic [7:0]       pwm_cnt_i,
`endif
  input  logic [CNT_W-1:0] wdata_i,
  output logic             out_o,
  output logic             busy_o
);
  mode_t            mode_q, mode_d;
  os_t              os_q, os_d;
  logic [CNT_W-1:0] hp_q, hp_d, cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             out_q, busy_q, pat_d, busy_d;
  logic             evt, counting, pwm_ok;

  // >= rather than == so a half-period lowered mid-count wraps on the next tick.
  assign evt      = (cnt_q >= hp_q);
  assign counting = (mode_q == MODE_BLINK) || (mode_q == MODE_ONESHOT && os_q == OS_HIGH);

  always_comb begin
    mode_d  = mode_q;
    os_d    = os_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (tick_i && ena_i && counting) begin
      cnt_d = evt ? '0 : cnt_q + 1'b1;
      if (evt) begin
        if (mode_q == MODE_BLINK) phase_d = ~phase_q;
        else                      os_d    = OS_DONE;
      end
    end
    // A mode write overrides a coincident event and restarts the channel.
    if (we_mode_i) begin
      mode_d  = mode_t'(wdata_i[1:0]);
      cnt_d   = '0;
      phase_d = 1'b0;
      os_d    = (mode_t'(wdata_i[1:0]) == MODE_ONESHOT) ? OS_HIGH : OS_IDLE;
    end
    if (we_hp_i) hp_d = wdata_i;
    pat_d = 1'b0;
    unique case (mode_d)
      MODE_OFF:     pat_d = 1'b0;
      MODE_ON:      pat_d = 1'b1;
      MODE_BLINK:   pat_d = phase_d;
      MODE_ONESHOT: pat_d = (os_d == OS_HIGH);
      default:      pat_d = 1'b0;
    endcase
    busy_d = (mode_d == MODE_ONESHOT) && (os_d == OS_HIGH);
  end

`ifdef BLINK_PWM_EN
  logic [7:0] duty_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            duty_q <= 8'hFF;
    else if (we_duty_i) duty_q <= wdata_i[7:0];
  end
  assign pwm_ok = (pwm_cnt_i <= duty_q);
`else
  assign pwm_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      os_q    <= OS_IDLE;
      hp_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      os_q    <= os_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= pat_d & pwm_ok;
      busy_q  <= busy_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;
endmodule

// File: rtl/blink_multi.sv
// Multi-channel LED pattern generator: shared prescaler, config decode, one blink_channel per output.
// BLINK_PWM_EN adds a free-running 8-bit pwm count feeding per-channel duty gating.
module blink_multi import blink_pkg::*; #(
  parameter int NCH       = 8,
  parameter int CNT_W     = 16,
  parameter int PRESC_DIV = 1
) (
  input logic         clk,
  input logic         rst,
  blink_multi_if.slave bus
);
  localparam int CH_W = ch_w(NCH);
  localparam int PW   = ch_w(PRESC_DIV);

  logic [PW-1:0]  presc_q, presc_d;
  logic           presc_wrap, tick;
  logic           wm, wh;
  logic [NCH-1:0] out_w, busy_w;

  assign presc_wrap = (presc_q == PW'(PRESC_DIV - 1));
  assign tick       = bus.ena & presc_wrap;
  assign presc_d    = !bus.ena ? presc_q : (presc_wrap ? '0 : presc_q + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign wm = bus.cfg_we && (bus.cfg_sel == SEL_MODE);
  assign wh = bus.cfg_we && (bus.cfg_sel == SEL_HP);

`ifdef BLINK_PWM_EN
  logic [7:0] pwm_q;
  logic       wd;
  assign wd = bus.cfg_we && (bus.cfg_sel == SEL_DUTY);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pwm_q <= '0;
    else if (bus.ena) pwm_q <= pwm_q + 1'b1;
  end
`endif

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = (bus.cfg_ch == CH_W'(i));
    blink_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ena_i     (bus.ena),
      .tick_i    (tick),
      .we_mode_i (wm && hit),
      .we_hp_i   (wh && hit),
`ifdef BLINK_PWM_EN
      .we_duty_i (wd && hit),
      .pwm_cnt_i (pwm_q),
`endif
      .wdata_i   (bus.cfg_data),
      .out_o     (out_w[i]),
      .busy_o    (busy_w[i])
    );
  end

  assign bus.out  = out_w;
  assign bus.busy = busy_w;
endmodule

// File: tb/tb_blink_multi.sv
// Scoreboard bench for blink_multi: driver queues hand-computed expectations, monitor checks at negedge.
module tb_blink_multi;
  import blink_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst4, ena, we_a, we_b;
  logic [2:0]  ch;
  logic [1:0]  sel;
  logic [15:0] data;
  int          cyc_n = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          ones3 = 0;

  blink_multi_if #(.NCH(8), .CNT_W(16)) bus_a ();
  blink_multi_if #(.NCH(8), .CNT_W(16)) bus_b ();

  assign bus_a.ena = ena;  assign bus_a.cfg_we = we_a; assign bus_a.cfg_ch = ch;
  assign bus_a.cfg_sel = sel; assign bus_a.cfg_data = data;
  assign bus_b.ena = ena;  assign bus_b.cfg_we = we_b; assign bus_b.cfg_ch = ch;
  assign bus_b.cfg_sel = sel; assign bus_b.cfg_data = data;

  blink_multi #(.NCH(8), .CNT_W(16), .PRESC_DIV(1)) dut  (.clk(clk), .rst(rst),  .bus(bus_a));
  blink_multi #(.NCH(8), .CNT_W(16), .PRESC_DIV(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus_b));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_n++; end

  typedef struct {
    int         cyc;
    bit         d4;
    bit         kind;
    logic [7:0] m, eo, eb;
    bit         cb;
    int         s0, en;
    string      nm;
  } exp_t;
  exp_t q[$];

  task automatic ex(string nm, bit d4, logic [7:0] m, logic [7:0] eo, logic [7:0] eb, bit cb);
    exp_t e;
    e.cyc = cyc_n; e.d4 = d4; e.kind = 1'b0; e.m = m; e.eo = eo; e.eb = eb;
    e.cb = cb; e.s0 = 0; e.en = 0; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic exb(string nm, bit d4, int c, bit o, bit b, bit cb);
    logic [7:0] m;
    m = 8'd1 << c;
    ex(nm, d4, m, o ? m : 8'd0, b ? m : 8'd0, cb);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic wr(bit b, logic [1:0] s, int c, int d);
    ch = 3'(c); sel = s; data = 16'(d);
    if (b) we_b = 1'b1; else we_a = 1'b1;
    cyc();
  endtask

  // Monitor: pops every expectation stamped for the current cycle.
  initial begin
    exp_t       e;
    logic [7:0] ao, ab;
    forever begin
      @(negedge clk);
      if (bus_a.out[3] === 1'b1) ones3++;
      while (q.size() != 0 && q[0].cyc <= cyc_n) begin
        e = q.pop_front();
        n_vec++;
        if (e.kind) begin
          if (e.cyc != cyc_n || (ones3 - e.s0) != e.en) begin
            n_bad++;
            $display("FAIL %s: high count %0d, expected %0d", e.nm, ones3 - e.s0, e.en);
          end
        end else begin
          ao = e.d4 ? bus_b.out  : bus_a.out;
          ab = e.d4 ? bus_b.busy : bus_a.busy;
          if (e.cyc != cyc_n || (ao & e.m) !== (e.eo & e.m) ||
              (e.cb && (ab & e.m) !== (e.eb & e.m))) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: out=%b busy=%b, expected out=%b busy=%b (mask %b)",
                     e.nm, cyc_n, ao, ab, e.eo, e.eb, e.m);
          end
        end
      end
    end
  end

  initial begin
    int j;
    rst = 1'b0; rst4 = 1'b1; ena = 1'b1; we_a = 1'b0; we_b = 1'b0;
    ch = '0; sel = '0; data = '0;
    #1 rst = 1'b1;
    cyc();

    // Reset with random config traffic, then all channels idle OFF.
    for (int k = 0; k < 3; k++) begin
      we_a = 1'($urandom); ch = 3'($urandom); sel = 2'($urandom); data = 16'($urandom);
      ex("reset_hold", 0, 8'hFF, 8'h00, 8'h00, 1);
      cyc();
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin ex("post_reset", 0, 8'hFF, 8'h00, 8'h00, 1); cyc(); end

    // BLINK hp=3: 4 low, 4 high.
    wr(0, SEL_HP, 0, 3); wr(0, SEL_MODE, 0, MODE_BLINK);
    for (int k = 0; k < 16; k++) begin exb("blink_hp3", 0, 0, 1'((k / 4) % 2), 0, 0); cyc(); end
    // BLINK hp=0: toggles every cycle.
    wr(0, SEL_HP, 1, 0); wr(0, SEL_MODE, 1, MODE_BLINK);
    for (int k = 0; k < 8; k++) begin exb("blink_hp0", 0, 1, 1'(k % 2), 0, 0); cyc(); end

    // ONESHOT hp=5: 6 cycles high/busy, then sticky DONE.
    wr(0, SEL_HP, 2, 5); wr(0, SEL_MODE, 2, MODE_ONESHOT);
    for (int k = 0; k < 10; k++) begin exb("oneshot", 0, 2, k < 6, k < 6, 1); cyc(); end
    wr(0, 2'd3, 2, 3);
    for (int k = 0; k < 4; k++) begin exb("sel3_ignored", 0, 2, 0, 0, 1); cyc(); end
    wr(0, SEL_MODE, 2, MODE_ONESHOT);
    for (int k = 0; k < 8; k++) begin exb("oneshot_retrig", 0, 2, k < 6, k < 6, 1); cyc(); end

    // ON / OFF take effect on the write edge.
    wr(0, SEL_MODE, 4, MODE_ON);  exb("mode_on", 0, 4, 1, 0, 1); cyc();
    wr(0, SEL_MODE, 4, MODE_OFF); exb("mode_off", 0, 4, 0, 0, 1); cyc();

    // Lower hp from 10 to 2 once the counter is at 7.
    wr(0, SEL_HP, 0, 10); wr(0, SEL_MODE, 0, MODE_BLINK);
    for (int k = 0; k < 7; k++) begin exb("hp10_pre", 0, 0, 0, 0, 0); cyc(); end
    exb("hp10_pre", 0, 0, 0, 0, 0);
    wr(0, SEL_HP, 0, 2);
    for (int m = 0; m < 11; m++) begin
      exb("hp_lowered", 0, 0, (m == 0) ? 1'b0 : 1'(((m - 1) / 3) % 2 == 0), 0, 0);
      cyc();
    end

    // ena low for 5 cycles freezes the pattern without losing phase.
    wr(0, SEL_HP, 0, 3); wr(0, SEL_MODE, 0, MODE_BLINK);
    j = 0;
    for (int t = 0; t < 26; t++) begin
      exb("ena_freeze", 0, 0, 1'((j / 4) % 2), 0, 0);
      ena = (t >= 6 && t < 11) ? 1'b0 : 1'b1;
      cyc();
      if (ena) j++;
    end
    ena = 1'b1;

    // PRESC_DIV=4, hp=1: 16-cycle period; first toggle on the second tick.
    ch = 3'd0; sel = SEL_HP; data = 16'd1; we_b = 1'b1; rst4 = 1'b0;
    cyc();
    wr(1, SEL_MODE, 0, MODE_BLINK);
    for (int s = 0; s < 24; s++) begin exb("presc4_blink", 1, 0, 1'(((s + 2) / 8) % 2), 0, 0); cyc(); end

    wr(0, SEL_MODE, 3, MODE_ON);
`ifdef BLINK_PWM_EN
    begin
      exp_t e;
      wr(0, SEL_DUTY, 3, 8'h3F);
      cyc();
      e.d4 = 0; e.kind = 1'b1; e.m = 0; e.eo = 0; e.eb = 0; e.cb = 0;
      e.s0 = ones3; e.en = 64; e.nm = "pwm_duty3f";
      for (int k = 0; k < 255; k++) cyc();
      e.cyc = cyc_n; q.push_back(e);
      cyc();
      wr(0, SEL_DUTY, 3, 8'hFF);
      cyc();
      e.s0 = ones3; e.en = 256; e.nm = "pwm_dutyff";
      for (int k = 0; k < 255; k++) cyc();
      e.cyc = cyc_n; q.push_back(e);
      cyc();
    end
`else
    exb("on_before_sel2", 0, 3, 1, 0, 1);
    wr(0, SEL_DUTY, 3, 0);
    for (int k = 0; k < 4; k++) begin exb("sel2_ignored", 0, 3, 1, 0, 1); cyc(); end
`endif

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
